serial_addsub: RTL and testbench

Multi-cycle, digit-serial adder/subtractor. It replaces single-bit combinational sum/carry cells in iterative datapaths such as the CORDIC hyperbolic/square-root stages, where area matters more than latency. Each cycle it processes DIGIT bits of a WIDTH-bit operand pair, LSB digit first. It uses a start/busy/done handshake and reports carry-out and signed overflow.

---
 rtl/serial_addsub.sv | 134 +++++++++++++
 tb/tb_serial_addsub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// Processes DIGIT bits per clock, least significant digit first, so a
// WIDTH-bit operation takes N = WIDTH/DIGIT cycles after the capture edge.
//
// Handshake: start is sampled only while busy=0. On the capture edge the
// operands, carry-in and mode are latched and busy rises. Each later edge
// consumes one digit. The edge that consumes the last digit drops busy and
// raises done for one cycle. s, c_out and ovf are valid from that cycle and
// are held until the next start is accepted. start may be asserted in the
// done cycle, which gives back-to-back operations with no idle cycle.
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;

   // The operand registers shift right each cycle, so the active digit is
   // always the low DIGIT bits. b_q already holds ~b for subtraction.
   logic [DIGIT-1:0] a_dig, b_dig;
   logic [DIGIT:0]   dig_sum;
   logic             dig_cout;
   logic             msb_cin;

   // Digit adder; the carry into the digit MSB is recovered from that bit's
   // sum, which is only meaningful for overflow on the last digit.
   always_comb begin
      a_dig    = a_q[DIGIT-1:0];
      b_dig    = b_q[DIGIT-1:0];
      dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      dig_cout = dig_sum[DIGIT];
      msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];
   end

   // Next-state and datapath update for the IDLE/RUN controller.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = mode ? ~b : b;
               carry_d = mode ? ~c_in : c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[cnt_q*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
            carry_d = dig_cout;
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
               c_out_d = dig_cout;
               ovf_d   = msb_cin ^ dig_cout;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = done_q;
   assign s     = s_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a 16/4 instance plus two 8-bit instances
// (DIGIT=1 and DIGIT=8) that share one set of inputs.
module tb_serial_addsub;

   // Clock and reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 16-bit, 4-bit digit instance
   logic        start16, mode16, cin16;
   logic [15:0] a16, b16;
   logic        busy16, done16, cout16, ovf16;
   logic [15:0] s16;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
      .a(a16), .b(b16), .c_in(cin16), .busy(busy16), .done(done16),
      .s(s16), .c_out(cout16), .ovf(ovf16));

   // 8-bit instances, bit-serial and single-cycle
   logic       start8, mode8, cin8;
   logic [7:0] a8, b8;
   logic       busy_s, done_s, cout_s, ovf_s;
   logic [7:0] s_s;
   logic       busy_p, done_p, cout_p, ovf_p;
   logic [7:0] s_p;

   serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8s (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
      .a(a8), .b(b8), .c_in(cin8), .busy(busy_s), .done(done_s),
      .s(s_s), .c_out(cout_s), .ovf(ovf_s));

   serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8p (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
      .a(a8), .b(b8), .c_in(cin8), .busy(busy_p), .done(done_p),
      .s(s_p), .c_out(cout_p), .ovf(ovf_p));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Start one 16-bit operation and wait for done; inputs are scrambled
   // while it runs. Returns at the sample point of the done cycle.
   task automatic run16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, output int lat, output int bcnt);
      @(negedge clk);
      mode16 = m; a16 = av; b16 = bv; cin16 = ci; start16 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      mode16 = 1'($urandom); cin16 = 1'($urandom);
      lat = 0; bcnt = 0;
      while (done16 !== 1'b1 && lat < 40) begin
         if (busy16 === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   // Start one operation on both 8-bit instances; report each latency/result.
   task automatic run8(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       output int lat_s, output logic [9:0] res_s,
                       output int lat_p, output logic [9:0] res_p);
      int j;
      @(negedge clk);
      mode8 = m; a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      j = 0; lat_s = -1; lat_p = -1; res_s = '0; res_p = '0;
      while ((lat_s < 0 || lat_p < 0) && j < 40) begin
         if (done_s === 1'b1 && lat_s < 0) begin lat_s = j; res_s = {s_s, cout_s, ovf_s}; end
         if (done_p === 1'b1 && lat_p < 0) begin lat_p = j; res_p = {s_p, cout_p, ovf_p}; end
         @(negedge clk);
         j++;
      end
   endtask

   typedef struct {
      logic        mode;
      logic [15:0] a;
      logic [15:0] b;
      logic        c_in;
      logic [15:0] exp_s;
      logic        exp_c;
      logic        exp_ovf;
   } vec16_t;

   typedef struct {
      logic       mode;
      logic [7:0] a;
      logic [7:0] b;
      logic       c_in;
      logic [7:0] exp_s;
      logic       exp_c;
      logic       exp_ovf;
   } vec8_t;

   vec16_t v16[10];
   vec8_t  v8[3];

   initial begin
      int lat, bcnt, ndone;
      int lat_s, lat_p;
      logic [9:0] res_s, res_p;

      v16[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      v16[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      v16[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      v16[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
      v16[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      v16[5] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b1, 1'b0};
      v16[6] = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
      v16[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      v16[8] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
      v16[9] = '{1'b0, 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};

      v8[0] = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
      v8[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      v8[2] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};

      start16 = 1'b0; mode16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
      start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;

      // Reset state
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy16", busy16, 0);
      chk("rst_done16", done16, 0);
      chk("rst_s16", s16, 0);
      chk("rst_cout16", cout16, 0);
      chk("rst_ovf16", ovf16, 0);
      chk("rst_busy8", {busy_s, busy_p, done_s, done_p}, 0);
      chk("rst_s8", {s_s, s_p}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table-driven 16-bit vectors
      for (int i = 0; i < 10; i++) begin
         run16(v16[i].mode, v16[i].a, v16[i].b, v16[i].c_in, lat, bcnt);
         chk($sformatf("v%0d_lat", i), lat, 4);
         chk($sformatf("v%0d_busy_cycles", i), bcnt, 4);
         chk($sformatf("v%0d_busy_at_done", i), busy16, 0);
         chk($sformatf("v%0d_s", i), s16, v16[i].exp_s);
         chk($sformatf("v%0d_cout", i), cout16, v16[i].exp_c);
         chk($sformatf("v%0d_ovf", i), ovf16, v16[i].exp_ovf);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done16, 0);
         chk($sformatf("v%0d_s_held", i), s16, v16[i].exp_s);
      end

      // start while busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      mode16 = 1'b0; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      @(negedge clk);
      a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b2b_done1", done16, 1);
      chk("b2b_s1", s16, 16'h3333);
      chk("b2b_cout1", cout16, 0);
      a16 = 16'h0101; b16 = 16'h0202; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      chk("b2b_busy2", busy16, 1);
      lat = 0;
      while (done16 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_lat2", lat, 4);
      chk("b2b_s2", s16, 16'h0303);

      // Asynchronous reset in the middle of an operation
      run16(1'b1, 16'h8000, 16'h0001, 1'b0, lat, bcnt);
      chk("pre_rst_ovf", ovf16, 1);
      @(negedge clk);
      mode16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy16, 0);
      chk("mid_rst_done", done16, 0);
      chk("mid_rst_s", s16, 0);
      chk("mid_rst_cout", cout16, 0);
      chk("mid_rst_ovf", ovf16, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done16 === 1'b1) ndone++;
      end
      chk("no_done_after_rst", ndone, 0);
      run16(1'b0, 16'h1234, 16'h1111, 1'b0, lat, bcnt);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_s", s16, 16'h2345);

      // 8-bit instances: DIGIT=1 (N=8) and DIGIT=8 (N=1)
      for (int i = 0; i < 3; i++) begin
         run8(v8[i].mode, v8[i].a, v8[i].b, v8[i].c_in, lat_s, res_s, lat_p, res_p);
         chk($sformatf("w8d1_%0d_lat", i), lat_s, 8);
         chk($sformatf("w8d1_%0d_res", i), res_s, {v8[i].exp_s, v8[i].exp_c, v8[i].exp_ovf});
         chk($sformatf("w8d8_%0d_lat", i), lat_p, 1);
         chk($sformatf("w8d8_%0d_res", i), res_p, {v8[i].exp_s, v8[i].exp_c, v8[i].exp_ovf});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
